// File: rtl/lfsr_prbs_burst_ctrl.sv
// lfsr_prbs_burst_ctrl: command-driven burst sequencer for a PRBS generator on an AXI-stream master
module lfsr_prbs_gen #(
  parameter int LFSR_WIDTH = 9,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY = 9'h021,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT = {LFSR_WIDTH{1'b1}},
  parameter string LFSR_CONFIG = "FIBONACCI",
  parameter bit REVERSE = 1'b0,
  parameter bit INVERT = 1'b0,
  parameter int DATA_WIDTH = 8,
  parameter string STYLE = "AUTO"
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic [DATA_WIDTH-1:0] data_out
);
  localparam bit GALOIS = LFSR_CONFIG == "GALOIS";
  logic [LFSR_WIDTH-1:0] state, state_next;
  logic [DATA_WIDTH-1:0] bits, rev;
  function automatic logic [LFSR_WIDTH-1:0] shift(input logic [LFSR_WIDTH-1:0] s);
    return GALOIS ? {s[LFSR_WIDTH-2:0], 1'b0} ^ (s[LFSR_WIDTH-1] ? LFSR_POLY : '0)
                  : {s[LFSR_WIDTH-2:0], s[LFSR_WIDTH-1] ^ (^(s[LFSR_WIDTH-2:0] & LFSR_POLY[LFSR_WIDTH-1:1]))};
  endfunction
  function automatic logic [DATA_WIDTH+LFSR_WIDTH-1:0] advance(input logic [LFSR_WIDTH-1:0] s0);
    logic [LFSR_WIDTH-1:0] s;
    logic [DATA_WIDTH-1:0] b;
    s = s0;
    b = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      b[DATA_WIDTH-1-i] = s[LFSR_WIDTH-1];
      s = shift(s);
    end
    return {b, s};
  endfunction
  generate
    if (STYLE == "UNROLL") begin : g_unroll
      logic [LFSR_WIDTH-1:0] chain [DATA_WIDTH+1];
      assign chain[0] = state;
      for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_step
        assign chain[i+1] = shift(chain[i]);
        assign bits[DATA_WIDTH-1-i] = chain[i][LFSR_WIDTH-1];
      end
      assign state_next = chain[DATA_WIDTH];
    end else begin : g_func
      assign {bits, state_next} = advance(state);
    end
  endgenerate
  assign rev = {<<{bits}};
  // one word of DATA_WIDTH LFSR steps per enable, held otherwise
  always_ff @(posedge clk)
    if (rst) begin
      state <= LFSR_INIT;
      data_out <= '0;
    end else if (enable) begin
      state <= state_next;
      data_out <= (REVERSE ? rev : bits) ^ {DATA_WIDTH{INVERT}};
    end
endmodule

module lfsr_prbs_burst_ctrl #(
  parameter int LFSR_WIDTH = 9,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY = 9'h021,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT = {LFSR_WIDTH{1'b1}},
  parameter string LFSR_CONFIG = "FIBONACCI",
  parameter bit REVERSE = 1'b0,
  parameter bit INVERT = 1'b0,
  parameter int DATA_WIDTH = 8,
  parameter string STYLE = "AUTO",
  parameter int COUNT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_start,
  input  logic [COUNT_WIDTH-1:0] cmd_len,
  input  logic cmd_reseed,
  output logic busy,
  output logic done,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic m_axis_tvalid,
  input  logic m_axis_tready,
  output logic m_axis_tlast,
  output logic [COUNT_WIDTH-1:0] words_sent
);
  typedef enum logic [2:0] {IDLE, EMPTY, RESEED, PRIME, STREAM, DONE} state_t;
  state_t state;
  logic [COUNT_WIDTH-1:0] remaining;
  logic gen_en, reseed;
  assign reseed = state == RESEED;
  assign gen_en = state == PRIME || (state == STREAM && m_axis_tready && !m_axis_tlast);
  lfsr_prbs_gen #(
    .LFSR_WIDTH(LFSR_WIDTH), .LFSR_POLY(LFSR_POLY), .LFSR_INIT(LFSR_INIT),
    .LFSR_CONFIG(LFSR_CONFIG), .REVERSE(REVERSE), .INVERT(INVERT),
    .DATA_WIDTH(DATA_WIDTH), .STYLE(STYLE)
  ) u_gen (
    .clk(clk),
    .rst(rst || reseed),
    .enable(gen_en),
    .data_out(m_axis_tdata)
  );
  // burst sequencer; a zero-length burst reports done alongside its single busy cycle
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      words_sent <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_start) begin
          remaining <= cmd_len;
          words_sent <= '0;
          busy <= 1'b1;
          done <= cmd_len == '0;
          state <= cmd_len == '0 ? EMPTY : cmd_reseed ? RESEED : PRIME;
        end
        EMPTY: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        RESEED: state <= PRIME;
        PRIME: begin
          m_axis_tvalid <= 1'b1;
          m_axis_tlast <= remaining == COUNT_WIDTH'(1);
          state <= STREAM;
        end
        STREAM: if (m_axis_tready) begin
          words_sent <= words_sent + 1'b1;
          remaining <= remaining - 1'b1;
          m_axis_tlast <= remaining == COUNT_WIDTH'(2);
          if (m_axis_tlast) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
